pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic elastic pipeline register that replaces the fixed-width, always-enabled inter-stage flops (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload bus per stage with a valid/ready handshake, a synchronous flush that inserts a bubble, and an optional one-entry skid buffer so that `in_ready` is registered.
- Keeps a saturating stall counter for performance debug.
- Instantiated once per stage boundary; the stage concatenates ALU op, register numbers, register values and immediate into `in_data`.

Parameters:
- `DATA_WIDTH`, 16, payload width in bits; legal range 1 or more.
- `NOP_VALUE`, {DATA_WIDTH{1'b0}}, payload presented on `out_data` whenever `out_valid`=0, and the value loaded on reset/flush.
- `SKID`, 1, 1 = two-entry elastic stage with registered `in_ready`; 0 = single-entry stage with combinational `in_ready`.
- `CNT_WIDTH`, 16, width of `stall_cnt`.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of all held entries.
- `clr_stats` in 1: synchronous clear of `stall_cnt`.
- `in_valid` in 1: upstream presents a beat.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_data` in DATA_WIDTH: upstream payload.
- `out_valid` out 1: stage presents a beat.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_WIDTH: oldest held payload, or `NOP_VALUE` when not valid.
- `occupancy` out 2: entries held (0..2).
- `stall_cnt` out CNT_WIDTH: cycles with `out_valid`=1 and `out_ready`=0.

Behaviour:
- **Definitions.** Accept = `in_valid`&`in_ready`. Emit = `out_valid`&`out_ready`.
- **Storage.** Main register holds the oldest entry. The skid register exists only when SKID=1.
- **Outputs.**
  - `out_valid` = (occupancy != 0).
  - `out_data` = main when valid, else `NOP_VALUE`.
- **Reset** (`rst`=0, async, immediate):
  - occupancy 0, `out_valid` 0, main = skid = `NOP_VALUE`, `stall_cnt` 0.
  - `in_ready` 1 (both SKID modes, since `out_valid`=0).
  - Reset asserted mid-transfer discards all entries.
  - First accept is possible on the first rising edge after `rst` deasserts.
- **SKID=1.** `in_ready` = (occupancy < 2), which depends only on state (registered). States:
  - EMPTY:
    - Accept -> ONE, main<=`in_data`.
    - Otherwise stay.
  - ONE:
    - Accept&Emit -> ONE, main<=`in_data`.
    - Accept only -> TWO, skid<=`in_data`.
    - Emit only -> EMPTY, main<=`NOP_VALUE`.
    - Neither -> hold.
  - TWO (`in_ready`=0):
    - Emit -> ONE, main<=skid, skid<=`NOP_VALUE`.
    - Otherwise hold.
- **SKID=0.**
  - `in_ready` = !`out_valid` | `out_ready` (combinational from `out_ready`).
  - States are EMPTY and ONE only.
  - Accept loads main, so back-to-back accept+emit holds ONE.
  - Emit without accept -> EMPTY.
  - `occupancy` never exceeds 1.
- **Flush.**
  - Highest priority over accept/emit; next state EMPTY, main and skid <= `NOP_VALUE`.
  - An accept in the flush cycle is discarded; upstream sees the handshake as completed.
  - An emit in the flush cycle is valid; downstream keeps that beat.
  - `in_ready` is not gated by `flush`.
- **Data stability.** While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold constant (AXI-style, no retraction), unless `flush` is asserted.
- **stall_cnt.**
  - +1 each cycle with `out_valid`=1 & `out_ready`=0.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - `clr_stats` sets it to 0 and wins over an increment in the same cycle.
  - Unaffected by `flush`.
- **Latency and throughput.**
  - One cycle from accept to `out_valid` in both modes.
  - Sustained throughput of 1 beat/cycle when `out_ready`=1.
- **Outputs driven from state.** All outputs come from registers, except `in_ready` when SKID=0 and the `NOP_VALUE` mux on `out_data`.

Test Plan:
- **Reset.** Hold `rst`=0 with `in_valid`=1 and `in_data`=16'hBEEF.
  - Required during and after reset: `out_valid`=0, `out_data`=16'h0000, `occupancy`=0, `in_ready`=1, `stall_cnt`=0.
- **Streaming.** SKID=1 and SKID=0, `out_ready`=1, drive 16'h0001..16'h0008 on consecutive cycles.
  - `out_data` shows the same sequence 1 cycle later, no gaps, `occupancy` stays 1.
- **Backpressure (SKID=1).** Drive 16'hA000, A001, A002 back-to-back with `out_ready`=0.
  - `occupancy` 1 then 2, `in_ready`=0 from the cycle after the second accept, A002 held upstream.
  - Then `out_ready`=1: outputs A000, A001, A002 in order.
  - `stall_cnt` equals the number of stalled cycles.
- **Flush while full (SKID=1).** Occupancy 2, assert `flush` with `in_valid`=1 and `in_data`=16'h5555.
  - Next cycle `occupancy`=0, `out_valid`=0, `out_data`=`NOP_VALUE`; 16'h5555 never appears.
  - Repeat with `NOP_VALUE`=16'h7F00 to check the bubble value.
- **Counter.** CNT_WIDTH=4, stall 20 cycles.
  - `stall_cnt` saturates at 15.
  - Assert `clr_stats` while still stalled: `stall_cnt`=0 on the next cycle and resumes counting from 1.
- **Async reset mid-operation.** Occupancy 2, pull `rst` low between clock edges.
  - `out_valid` drops immediately, without waiting for `clk`.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two pipeline stages: valid/ready handshake,
// synchronous flush that inserts a bubble, optional skid entry, saturating stall counter.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | main holds the oldest beat
// ST_TWO   | main and skid both held (SKID=1 only)
module pipe_stage_reg #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
  parameter bit                    SKID       = 1'b1,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_stats,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] main_q, main_nxt;
  logic [DATA_WIDTH-1:0] skid_q, skid_nxt;
  logic                  accept, emit;

  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  generate
    if (SKID) begin : g_skid
      // Ready depends only on state, so it can be used as a registered signal upstream.
      assign in_ready = (state_q != ST_TWO);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) skid_q <= NOP_VALUE;
        else      skid_q <= skid_nxt;
      end
    end else begin : g_no_skid
      assign in_ready = !out_valid || out_ready;
      assign skid_q   = NOP_VALUE;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
    end else begin
      state_q <= state_nxt;
      main_q  <= main_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // A beat accepted in the flush cycle is dropped; an emitted one has already left.
      state_nxt = ST_EMPTY;
      main_nxt  = NOP_VALUE;
      skid_nxt  = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_nxt = in_data;
          end else if (accept) begin
            state_nxt = ST_TWO;
            skid_nxt  = in_data;
          end else if (emit) begin
            state_nxt = ST_EMPTY;
            main_nxt  = NOP_VALUE;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_nxt = ST_ONE;
            main_nxt  = skid_q;
            skid_nxt  = NOP_VALUE;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = NOP_VALUE;
          skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Four configurations of pipe_stage_reg driven by shared stimulus, each checked every
// cycle against a FIFO-level reference, plus directed literal expectations.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c, ir_d, ov_d;
  logic [15:0] od_a, od_b, od_c, od_d;
  logic [1:0]  oc_a, oc_b, oc_c, oc_d;
  logic [15:0] sc_a, sc_b, sc_c;
  logic [3:0]  sc_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: default SKID=1, b: SKID=0, c: SKID=1 with non-zero bubble, d: SKID=1 with 4-bit counter
  pipe_stage_reg #(.DATA_WIDTH(16), .NOP_VALUE(16'h0000), .SKID(1'b1), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats), .in_valid(in_valid),
    .in_ready(ir_a), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .occupancy(oc_a), .stall_cnt(sc_a));
  pipe_stage_reg #(.DATA_WIDTH(16), .NOP_VALUE(16'h0000), .SKID(1'b0), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats), .in_valid(in_valid),
    .in_ready(ir_b), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .occupancy(oc_b), .stall_cnt(sc_b));
  pipe_stage_reg #(.DATA_WIDTH(16), .NOP_VALUE(16'h7F00), .SKID(1'b1), .CNT_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats), .in_valid(in_valid),
    .in_ready(ir_c), .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready),
    .out_data(od_c), .occupancy(oc_c), .stall_cnt(sc_c));
  pipe_stage_reg #(.DATA_WIDTH(16), .NOP_VALUE(16'h0000), .SKID(1'b1), .CNT_WIDTH(4)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats), .in_valid(in_valid),
    .in_ready(ir_d), .in_data(in_data), .out_valid(ov_d), .out_ready(out_ready),
    .out_data(od_d), .occupancy(oc_d), .stall_cnt(sc_d));

  // Reference: a FIFO of capacity 2 (skid) or 1, plus a saturating stall count.
  bit          skid_m [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] nop_m  [4] = '{16'h0000, 16'h0000, 16'h7F00, 16'h0000};
  int          smax   [4] = '{65535, 65535, 65535, 15};
  int          n      [4] = '{0, 0, 0, 0};
  logic [15:0] fifo   [4][2];
  int          sc     [4] = '{0, 0, 0, 0};

  function automatic bit mrdy(input int i);
    if (skid_m[i]) return n[i] < 2;
    return (n[i] == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        n[i]  = 0;
        sc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin : step
        bit acc, emt;
        acc = in_valid && mrdy(i);
        emt = (n[i] > 0) && out_ready;
        if (clr_stats) sc[i] = 0;
        else if ((n[i] > 0) && !out_ready && (sc[i] < smax[i])) sc[i] = sc[i] + 1;
        if (flush) begin
          n[i] = 0;
        end else begin
          if (emt) begin
            fifo[i][0] = fifo[i][1];
            n[i] = n[i] - 1;
          end
          if (acc) begin
            fifo[i][n[i]] = in_data;
            n[i] = n[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic ov, input logic [15:0] od,
                          input logic [1:0] oc, input logic ir, input int scv);
    logic [15:0] exp_d;
    exp_d = (n[i] > 0) ? fifo[i][0] : nop_m[i];
    chk($sformatf("u%0d out_valid", i), 32'(ov), 32'(n[i] > 0));
    chk($sformatf("u%0d out_data", i), 32'(od), 32'(exp_d));
    chk($sformatf("u%0d occupancy", i), 32'(oc), 32'(n[i]));
    chk($sformatf("u%0d in_ready", i), 32'(ir), 32'(mrdy(i)));
    chk($sformatf("u%0d stall_cnt", i), 32'(scv), 32'(sc[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, ov_a, od_a, oc_a, ir_a, int'(sc_a));
    cmp_inst(1, ov_b, od_b, oc_b, ir_b, int'(sc_b));
    cmp_inst(2, ov_c, od_c, oc_c, ir_c, int'(sc_c));
    cmp_inst(3, ov_d, od_d, oc_d, ir_d, int'(sc_d));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b0;
    #12;
    chk("rst a out_valid", 32'(ov_a), 0);
    chk("rst a out_data", 32'(od_a), 32'h0000);
    chk("rst a occupancy", 32'(oc_a), 0);
    chk("rst a in_ready", 32'(ir_a), 1);
    chk("rst b in_ready", 32'(ir_b), 1);
    chk("rst a stall_cnt", 32'(sc_a), 0);
    chk("rst c out_data", 32'(od_c), 32'h7F00);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    chk("post rst a out_valid", 32'(ov_a), 0);
    chk("post rst a in_ready", 32'(ir_a), 1);

    // streaming
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 16'(k);
      cyc();
      chk("stream a data", 32'(od_a), 32'(k));
      chk("stream a occ", 32'(oc_a), 1);
      chk("stream b data", 32'(od_b), 32'(k));
      chk("stream b occ", 32'(oc_b), 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("drain a occ", 32'(oc_a), 0);
    chk("drain b occ", 32'(oc_b), 0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA000;
    cyc();
    chk("bp a occ1", 32'(oc_a), 1);
    chk("bp a ready1", 32'(ir_a), 1);
    in_data = 16'hA001;
    cyc();
    chk("bp a occ2", 32'(oc_a), 2);
    chk("bp a ready2", 32'(ir_a), 0);
    chk("bp a head", 32'(od_a), 32'hA000);
    in_data = 16'hA002;
    cyc();
    chk("bp a occ held", 32'(oc_a), 2);
    chk("bp a head held", 32'(od_a), 32'hA000);
    chk("bp a stall", 32'(sc_a), 2);
    out_ready = 1'b1;
    cyc();
    chk("bp a second", 32'(od_a), 32'hA001);
    cyc();
    chk("bp a third", 32'(od_a), 32'hA002);
    in_valid = 1'b0;
    cyc();
    chk("bp a empty", 32'(oc_a), 0);
    chk("bp a stall final", 32'(sc_a), 2);

    // flush while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1111;
    cyc();
    in_data = 16'h2222;
    cyc();
    chk("fl a occ2", 32'(oc_a), 2);
    chk("fl c occ2", 32'(oc_c), 2);
    flush = 1'b1; in_data = 16'h5555;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl a occ", 32'(oc_a), 0);
    chk("fl a out_valid", 32'(ov_a), 0);
    chk("fl a out_data", 32'(od_a), 32'h0000);
    chk("fl c out_data", 32'(od_c), 32'h7F00);
    cyc();
    chk("fl a still empty", 32'(oc_a), 0);

    // counter saturation
    in_valid = 1'b1; in_data = 16'h3333; clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0; in_valid = 1'b0;
    repeat (20) cyc();
    chk("cnt d sat", 32'(sc_d), 15);
    chk("cnt a 20", 32'(sc_a), 20);
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    chk("cnt d clr", 32'(sc_d), 0);
    cyc();
    chk("cnt d resume", 32'(sc_d), 1);

    // async reset mid-operation
    in_valid = 1'b1; in_data = 16'h4444;
    cyc();
    in_valid = 1'b0;
    chk("ar a occ2", 32'(oc_a), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar a out_valid", 32'(ov_a), 0);
    chk("ar a occ", 32'(oc_a), 0);
    chk("ar a stall", 32'(sc_a), 0);
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      out_ready = (t < 1500) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      flush     = (($urandom % 16) == 0);
      clr_stats = (($urandom % 32) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
